dp_bram: RTL and testbench

True dual-port synchronous block RAM with two independent read/write ports sharing one clock. It is the sector/track buffer between the SD-card block interface (port A) and the emulated drive controller (port B) in the disk loaders, and is also used as a generic on-chip RAM. The design is behavioral RTL that infers FPGA block RAM, with explicit collision and forwarding logic around the array.

---
 rtl/dp_bram.sv | 100 ++++++++++
 tb/tb_dp_bram.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dp_bram.sv
`default_nettype none
// ============================================================================
// Module      : dp_bram
// Description : True dual-port synchronous block RAM, one shared clock.
//               Port A and port B each read every cycle and may write.
//               Registered read data, one cycle of read latency.
//               Same-address dual write: port A's data is stored.
//               Synchronous active-low reset clears q_a/q_b and blocks
//               writes; array contents are retained across reset.
//               Optional macro DP_BRAM_BYPASS_EN selects write-first
//               forwarding on collisions (default build is read-first).
// Revision    : 1.0 - initial release
// ============================================================================
module dp_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic                  wren_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  wren_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    // Storage array; its address range covers every address input value,
    // so addresses wrap naturally modulo the depth.
    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    // Pre-write contents of the addressed words (read-first view).
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    // Next values loaded into the output registers.
    logic [DATA_WIDTH-1:0] w_q_a_next;
    logic [DATA_WIDTH-1:0] w_q_b_next;

    assign w_rd_a = r_mem[address_a];
    assign w_rd_b = r_mem[address_b];

`ifdef DP_BRAM_BYPASS_EN
    // Address match between the two ports, used for cross-port forwarding.
    logic w_same_addr;
    assign w_same_addr = (address_a == address_b);

    // Write-first forwarding: a writing port sees its own data, the other
    // port sees the stored (winning) data; port A wins a dual-write tie.
    always_comb begin
        w_q_a_next = w_rd_a;
        w_q_b_next = w_rd_b;
        if (wren_a) begin
            w_q_a_next = data_a;
        end else if (wren_b && w_same_addr) begin
            w_q_a_next = data_b;
        end
        if (wren_a && w_same_addr) begin
            w_q_b_next = data_a;
        end else if (wren_b) begin
            w_q_b_next = data_b;
        end
    end
`else
    // Read-first: both ports always return the pre-write word.
    always_comb begin
        w_q_a_next = w_rd_a;
        w_q_b_next = w_rd_b;
    end
`endif

    // Array writes; port A is assigned last so it wins a same-address tie.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (wren_b) begin
                r_mem[address_b] <= data_b;
            end
            if (wren_a) begin
                r_mem[address_a] <= data_a;
            end
        end
    end

    // Registered read data, cleared while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= w_q_a_next;
            q_b <= w_q_b_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_bram.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_bram
// Description : Self-checking bench for dp_bram: directed scenarios followed
//               by randomized traffic, compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_bram;

    localparam int DW = 8;
    localparam int AW = 14;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] address_a;
    logic          wren_a;
    logic [DW-1:0] data_a;
    logic [DW-1:0] q_a;
    logic [AW-1:0] address_b;
    logic          wren_b;
    logic [DW-1:0] data_b;
    logic [DW-1:0] q_b;

    int vectors;
    int miscompares;
    int step_no;

    // Behavioural model of the array contents (starts all zero).
    bit [DW-1:0] model [0:(2**AW)-1];

    dp_bram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address_a (address_a),
        .wren_a    (wren_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .address_b (address_b),
        .wren_b    (wren_b),
        .data_b    (data_b),
        .q_b       (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict outputs from the model, update the
    // model, then sample and compare after the edge.
    task automatic step(input logic [AW-1:0] aa, input logic wa, input logic [DW-1:0] da,
                        input logic [AW-1:0] ab, input logic wb, input logic [DW-1:0] db,
                        input logic rn);
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        address_a = aa; wren_a = wa; data_a = da;
        address_b = ab; wren_b = wb; data_b = db;
        reset_n   = rn;
        step_no++;
        if (!rn) begin
            ea = '0;
            eb = '0;
        end else begin
            ea = model[aa];
            eb = model[ab];
`ifdef DP_BRAM_BYPASS_EN
            if (wa)                  ea = da;
            else if (wb && aa == ab) ea = db;
            if (wa && aa == ab)      eb = da;
            else if (wb)             eb = db;
`endif
            if (wb && !(wa && aa == ab)) model[ab] = db;
            if (wa)                      model[aa] = da;
        end
        @(posedge clk);
        #1;
        check("q_a", q_a, ea);
        check("q_b", q_b, eb);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] addrs [4];
        vectors     = 0;
        miscompares = 0;
        step_no     = 0;
        reset_n   = 1'b0;
        address_a = '0; wren_a = 1'b0; data_a = '0;
        address_b = '0; wren_b = 1'b0; data_b = '0;

        // Reset with a pending write: outputs zero, write suppressed.
        step(14'd5, 1'b1, 8'hAA, 14'd0, 1'b0, 8'h00, 1'b0);
        step(14'd5, 1'b1, 8'hAA, 14'd0, 1'b0, 8'h00, 1'b0);
        check("reset_q_a", q_a, 8'h00);
        step(14'd5, 1'b0, 8'h00, 14'd5, 1'b0, 8'h00, 1'b1);
        check("after_reset_mem5", q_a, 8'h00);

        // Basic cross-port write then read.
        step(14'h1FF, 1'b1, 8'h5A, 14'd0, 1'b0, 8'h00, 1'b1);
        step(14'd0, 1'b0, 8'h00, 14'h1FF, 1'b0, 8'h00, 1'b1);
        check("cross_port_5A", q_b, 8'h5A);

        // Full address range via port B, read back via port A.
        addrs = '{14'h0000, 14'h0001, 14'h1000, 14'h3FFF};
        foreach (addrs[i]) step(14'd0, 1'b0, 8'h00, addrs[i], 1'b1, addrs[i][7:0] ^ 8'hC3, 1'b1);
        foreach (addrs[i]) step(addrs[i], 1'b0, 8'h00, 14'd0, 1'b0, 8'h00, 1'b1);
        check("no_alias_3FFF", q_a, 8'h3C);

        // Same-address read during write.
        step(14'd7, 1'b1, 8'h11, 14'd0, 1'b0, 8'h00, 1'b1);
        step(14'd7, 1'b1, 8'h22, 14'd7, 1'b0, 8'h00, 1'b1);
        step(14'd7, 1'b0, 8'h00, 14'd7, 1'b0, 8'h00, 1'b1);
        check("rdw_followup_b", q_b, 8'h22);

        // Dual-write collision: port A wins.
        step(14'd9, 1'b1, 8'h33, 14'd9, 1'b1, 8'h44, 1'b1);
        step(14'd9, 1'b0, 8'h00, 14'd9, 1'b0, 8'h00, 1'b1);
        check("collision_a_wins", q_b, 8'h33);

        // Independent dual write.
        step(14'd3, 1'b1, 8'h01, 14'd4, 1'b1, 8'h02, 1'b1);
        step(14'd3, 1'b0, 8'h00, 14'd4, 1'b0, 8'h00, 1'b1);
        check("indep_a", q_a, 8'h01);
        check("indep_b", q_b, 8'h02);

        // Randomized traffic over a small window so collisions are frequent,
        // with occasional top-of-range addresses and reset pulses.
        for (int n = 0; n < 400; n++) begin
            ra = 14'($urandom_range(0, 15));
            rb = 14'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra = ra | 14'h3FF0;
            if ($urandom_range(0, 7) == 0) rb = rb | 14'h3FF0;
            step(ra, 1'($urandom_range(0, 1)), 8'($urandom),
                 rb, 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 19) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
